// File: rtl/l2_pmem_burst_responder_if.sv
// Bundle of the cache-side line port and the beat-serial memory bus seen by
// l2_pmem_burst_responder; slave is the responder, master is its environment.
interface l2_pmem_burst_responder_if #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
);
  logic                  pmem_read;
  logic                  pmem_write;
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;
  logic                  mb_cmd_valid;
  logic                  mb_cmd_ready;
  logic                  mb_cmd_write;
  logic [ADDR_WIDTH-1:0] mb_cmd_address;
  logic [BEAT_WIDTH-1:0] mb_wdata;
  logic                  mb_wvalid;
  logic                  mb_wready;
  logic                  mb_bdone;
  logic [BEAT_WIDTH-1:0] mb_rdata;
  logic                  mb_rvalid;
  logic                  err;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  mb_cmd_ready, mb_wready, mb_bdone, mb_rdata, mb_rvalid,
    output pmem_rdata, pmem_resp, mb_cmd_valid, mb_cmd_write, mb_cmd_address,
    output mb_wdata, mb_wvalid, err
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    output mb_cmd_ready, mb_wready, mb_bdone, mb_rdata, mb_rvalid,
    input  pmem_rdata, pmem_resp, mb_cmd_valid, mb_cmd_write, mb_cmd_address,
    input  mb_wdata, mb_wvalid, err
  );
endinterface

// File: rtl/l2_pmem_burst_responder.sv
// Converts whole-line L2 pmem read/write requests into command + beat bursts on
// a narrower memory bus, reassembling read lines; every output is registered.
module l2_pmem_burst_responder #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic clk,
  input  logic reset_n,
  l2_pmem_burst_responder_if.slave bus
);
  localparam int NBEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_WBEAT = 3'd2;
  localparam logic [2:0] S_WWAIT = 3'd3;
  localparam logic [2:0] S_RBEAT = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]            state_r;
  logic [2:0]            state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_inc_s;
  logic                  write_r;
  logic [LINE_WIDTH-1:0] wline_r;
  logic [LINE_WIDTH-1:0] rbuf_r;
  logic [ADDR_WIDTH-1:0] cmd_addr_r;
  logic [BEAT_WIDTH-1:0] wdata_r;
  logic                  cmd_valid_r;
  logic                  wvalid_r;
  logic                  resp_r;
  logic                  err_r;
  logic                  cmd_hs_s;
  logic                  w_hs_s;
  logic                  last_s;
  logic                  req_held_s;
  logic                  busy_s;
  logic                  err_s;

  // Next-state decode and protocol-error detection.
  always_comb begin
    state_s    = state_r;
    cmd_hs_s   = cmd_valid_r && bus.mb_cmd_ready;
    w_hs_s     = wvalid_r && bus.mb_wready;
    last_s     = (cnt_r == LAST_BEAT);
    cnt_inc_s  = cnt_r + CNT_W'(1);
    req_held_s = write_r ? bus.pmem_write : bus.pmem_read;
    busy_s     = (state_r == S_CMD) || (state_r == S_WBEAT) ||
                 (state_r == S_WWAIT) || (state_r == S_RBEAT);
    case (state_r)
      S_IDLE: begin
        if (bus.pmem_write || bus.pmem_read) state_s = S_CMD;
        else                                 state_s = S_IDLE;
      end
      S_CMD: begin
        if (cmd_hs_s && write_r) state_s = S_WBEAT;
        else if (cmd_hs_s)       state_s = S_RBEAT;
        else                     state_s = S_CMD;
      end
      S_WBEAT: begin
        if (w_hs_s && last_s) state_s = S_WWAIT;
        else                  state_s = S_WBEAT;
      end
      S_WWAIT: begin
        if (bus.mb_bdone) state_s = S_RESP;
        else              state_s = S_WWAIT;
      end
      S_RBEAT: begin
        if (bus.mb_rvalid && last_s) state_s = S_RESP;
        else                         state_s = S_RBEAT;
      end
      S_RESP:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
    err_s = (bus.mb_rvalid && (state_r != S_RBEAT)) ||
            (bus.mb_bdone && (state_r != S_WWAIT)) ||
            (busy_s && !req_held_s);
  end

  // State, beat counter, line buffers and registered bus outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      write_r     <= 1'b0;
      wline_r     <= '0;
      rbuf_r      <= '0;
      cmd_addr_r  <= '0;
      wdata_r     <= '0;
      cmd_valid_r <= 1'b0;
      wvalid_r    <= 1'b0;
      resp_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r <= state_s;
      resp_r  <= (state_s == S_RESP);
      if (err_s) err_r <= 1'b1;
      case (state_r)
        S_IDLE: begin
          if (state_s == S_CMD) begin
            write_r     <= bus.pmem_write;
            cmd_addr_r  <= bus.pmem_address & ADDR_MASK;
            wline_r     <= bus.pmem_wdata;
            cmd_valid_r <= 1'b1;
            cnt_r       <= '0;
          end
        end
        S_CMD: begin
          if (cmd_hs_s) begin
            cmd_valid_r <= 1'b0;
            if (write_r) begin
              wvalid_r <= 1'b1;
              wdata_r  <= wline_r[BEAT_WIDTH-1:0];
            end
          end
        end
        S_WBEAT: begin
          // Preload the following beat so mb_wdata stays a plain register.
          if (w_hs_s) begin
            cnt_r <= cnt_inc_s;
            if (last_s) wvalid_r <= 1'b0;
            else        wdata_r  <= wline_r[int'(cnt_inc_s)*BEAT_WIDTH +: BEAT_WIDTH];
          end
        end
        S_RBEAT: begin
          if (bus.mb_rvalid) begin
            rbuf_r[int'(cnt_r)*BEAT_WIDTH +: BEAT_WIDTH] <= bus.mb_rdata;
            cnt_r <= cnt_inc_s;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.pmem_rdata     = rbuf_r;
  assign bus.pmem_resp      = resp_r;
  assign bus.mb_cmd_valid   = cmd_valid_r;
  assign bus.mb_cmd_write   = write_r;
  assign bus.mb_cmd_address = cmd_addr_r;
  assign bus.mb_wdata       = wdata_r;
  assign bus.mb_wvalid      = wvalid_r;
  assign bus.err            = err_r;
endmodule

// File: tb/tb_l2_pmem_burst_responder.sv
// Scoreboard bench for l2_pmem_burst_responder: a memory-side bus model plus a
// queue of expected responses that is drained whenever pmem_resp pulses.
module tb_l2_pmem_burst_responder;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 16;
  localparam int NB = LW / BW;

  typedef struct {
    bit          is_read;
    logic [LW-1:0] line;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  l2_pmem_burst_responder_if #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) bus ();

  l2_pmem_burst_responder #(.LINE_WIDTH(LW), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cyc;
  int resp_cnt = 0;
  int bdone_cyc = 0;
  bit stall_en = 1'b0;
  int bdone_dly = 0;
  int wstall_beat = -1;
  int wstall_cycles = 0;
  int poke_rv_req = 0, poke_rv_done = 0;
  int poke_bd_req = 0, poke_bd_done = 0;

  exp_t           exp_q[$];
  int             resp_cyc_q[$];
  logic [AW:0]    cmd_log[$];
  logic [BW-1:0]  wbeat_log[$];
  logic [LW-1:0]  mem    [logic [AW-1:0]];
  logic [LW-1:0]  sb_mem [logic [AW-1:0]];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] default_line(input logic [AW-1:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = {a, 16'(k), ~a, 16'hC0DE};
    return l;
  endfunction

  function automatic logic [LW-1:0] model_line(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : default_line(a);
  endfunction

  function automatic logic [LW-1:0] sb_line(input logic [AW-1:0] a);
    return sb_mem.exists(a) ? sb_mem[a] : default_line(a);
  endfunction

  function automatic logic [84:0] outs_flat();
    return {bus.pmem_resp, bus.mb_cmd_valid, bus.mb_cmd_write, bus.mb_cmd_address,
            bus.mb_wdata, bus.mb_wvalid, bus.err};
  endfunction

  task automatic serve_read(input logic [AW-1:0] a);
    logic [LW-1:0] line;
    line = model_line(a);
    for (int k = 0; k < NB; k++) begin
      while (stall_en && $urandom_range(0, 2) == 0) begin
        bus.mb_rvalid = 1'b0;
        @(posedge clk); #1;
      end
      bus.mb_rvalid = 1'b1;
      bus.mb_rdata  = line[k*BW +: BW];
      if (k == 1 && poke_bd_done != poke_bd_req) begin
        bus.mb_bdone = 1'b1;
        poke_bd_done++;
      end
      @(posedge clk); #1;
      bus.mb_rvalid = 1'b0;
      bus.mb_bdone  = 1'b0;
    end
  endtask

  task automatic serve_write(input logic [AW-1:0] a);
    logic [LW-1:0] line;
    int beats, guard, stall_left, dly;
    line = '0; beats = 0; guard = 0; stall_left = wstall_cycles;
    while (beats < NB && guard < 300) begin
      if (beats == wstall_beat && stall_left > 0) begin
        bus.mb_wready = 1'b0;
        stall_left--;
      end else begin
        bus.mb_wready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(posedge clk);
      if (reset_n !== 1'b1) begin
        #1;
        bus.mb_wready = 1'b0;
        return;
      end
      if (bus.mb_wvalid && bus.mb_wready) begin
        line[beats*BW +: BW] = bus.mb_wdata;
        wbeat_log.push_back(bus.mb_wdata);
        beats++;
      end
      guard++;
      #1;
    end
    bus.mb_wready = 1'b0;
    if (beats == NB) begin
      dly = stall_en ? int'($urandom_range(0, 3)) : bdone_dly;
      repeat (dly) begin @(posedge clk); #1; end
      bus.mb_bdone = 1'b1;
      bdone_cyc = cyc;
      mem[a] = line;
      @(posedge clk); #1;
      bus.mb_bdone = 1'b0;
    end
  endtask

  // Memory-side bus model.
  initial begin : mem_model
    logic [AW-1:0] a;
    logic          w;
    bus.mb_cmd_ready = 1'b0;
    bus.mb_wready    = 1'b0;
    bus.mb_bdone     = 1'b0;
    bus.mb_rdata     = '0;
    bus.mb_rvalid    = 1'b0;
    forever begin
      @(posedge clk);
      if (reset_n === 1'b1 && bus.mb_cmd_valid === 1'b1 && bus.mb_cmd_ready === 1'b1) begin
        a = bus.mb_cmd_address;
        w = bus.mb_cmd_write;
        cmd_log.push_back({w, a});
        #1;
        bus.mb_cmd_ready = 1'b0;
        if (w) serve_write(a);
        else   serve_read(a);
      end else begin
        #1;
      end
      if (poke_rv_done != poke_rv_req) begin
        bus.mb_rvalid = 1'b1;
        poke_rv_done++;
      end else begin
        bus.mb_rvalid = 1'b0;
      end
      bus.mb_cmd_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Response monitor: every pmem_resp consumes one scoreboard entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.pmem_resp === 1'b1) begin
        resp_cnt++;
        resp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check_val("resp_extra", 1, 0);
        end else begin
          e = exp_q.pop_front();
          if (e.is_read) check_val("rdata", bus.pmem_rdata, e.line);
        end
      end
    end
  end

  task automatic do_req(input bit wr, input bit rd, input logic [AW-1:0] a, input logic [LW-1:0] line);
    logic [AW-1:0] al;
    int need, waited;
    exp_t e;
    al = a & 16'hFFE0;
    @(posedge clk); #1;
    req_cyc = cyc;
    bus.pmem_address = a;
    bus.pmem_wdata   = line;
    bus.pmem_write   = wr;
    bus.pmem_read    = rd;
    if (wr) begin e.is_read = 1'b0; e.line = line; exp_q.push_back(e); sb_mem[al] = line; end
    if (rd) begin e.is_read = 1'b1; e.line = sb_line(al); exp_q.push_back(e); end
    need = int'(wr) + int'(rd);
    while (need > 0) begin
      waited = 0;
      do begin @(negedge clk); waited++; end while (bus.pmem_resp !== 1'b1 && waited < 500);
      if (bus.pmem_resp !== 1'b1) begin
        check_val("resp_timeout", 0, 1);
        need = 0;
      end else begin
        need--;
      end
      @(posedge clk); #1;
      if (need == 1) bus.pmem_write = 1'b0;
    end
    bus.pmem_write = 1'b0;
    bus.pmem_read  = 1'b0;
  endtask

  initial begin : main
    int rc, n, base, w, op, exp_resps;
    logic [AW-1:0] a;
    logic [LW-1:0] l;
    reset_n = 1'b0;
    bus.pmem_read = 1'b0; bus.pmem_write = 1'b0;
    bus.pmem_address = '0; bus.pmem_wdata = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outs", outs_flat(), 0);
    check_val("reset_rdata", bus.pmem_rdata, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed read with zero-wait bus
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    mem[16'h1220] = l;
    sb_mem[16'h1220] = l;
    do_req(1'b0, 1'b1, 16'h1234, '0);
    check_val("rd_cmd", cmd_log[$], {1'b0, 16'h1220});
    check_val("rd_latency", resp_cyc_q[$] - req_cyc, 6);

    // Write with a wready stall before beat 2 and late bdone
    wstall_beat = 2; wstall_cycles = 2; bdone_dly = 2;
    base = wbeat_log.size(); rc = resp_cnt;
    do_req(1'b1, 1'b0, 16'h0040, {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                  64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD});
    check_val("wr_cmd", cmd_log[$], {1'b1, 16'h0040});
    check_val("wr_beat0", wbeat_log[base + 0], 64'hDDDD_DDDD_DDDD_DDDD);
    check_val("wr_beat1", wbeat_log[base + 1], 64'hCCCC_CCCC_CCCC_CCCC);
    check_val("wr_beat2", wbeat_log[base + 2], 64'hBBBB_BBBB_BBBB_BBBB);
    check_val("wr_beat3", wbeat_log[base + 3], 64'hAAAA_AAAA_AAAA_AAAA);
    check_val("wr_resp_cnt", resp_cnt - rc, 1);
    check_val("wr_resp_after_bdone", resp_cyc_q[$] - bdone_cyc, 1);
    wstall_beat = -1; wstall_cycles = 0; bdone_dly = 0;
    do_req(1'b0, 1'b1, 16'h0040, '0);

    // Simultaneous read and write: write first, then read after one IDLE cycle
    rc = resp_cnt;
    do_req(1'b1, 1'b1, 16'h0100, {8{32'h5A5A_0F0F}} ^ {4{64'h0123_4567_89AB_CDEF}});
    n = resp_cyc_q.size();
    check_val("rw_resp_cnt", resp_cnt - rc, 2);
    check_val("rw_wr_latency", resp_cyc_q[n-2] - req_cyc, 7);
    check_val("rw_rd_latency", resp_cyc_q[n-1] - req_cyc, 14);
    check_val("rw_cmd_first", cmd_log[cmd_log.size()-2], {1'b1, 16'h0100});
    check_val("rw_cmd_second", cmd_log[cmd_log.size()-1], {1'b0, 16'h0100});

    // Stray rvalid in IDLE
    check_val("err_clear", bus.err, 0);
    poke_rv_req++;
    repeat (4) begin @(posedge clk); #1; end
    check_val("err_rvalid", bus.err, 1);
    rc = resp_cnt;
    do_req(1'b0, 1'b1, 16'h1234, '0);
    check_val("err_rd_resp", resp_cnt - rc, 1);
    reset_n = 1'b0;
    #1;
    check_val("err_reset", bus.err, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    // Stray bdone during a read burst
    poke_bd_req++;
    rc = resp_cnt;
    do_req(1'b0, 1'b1, 16'h0040, '0);
    check_val("err_bdone", bus.err, 1);
    check_val("err_bd_resp", resp_cnt - rc, 1);

    // Reset in the middle of a write burst
    @(posedge clk); #1;
    base = wbeat_log.size();
    bus.pmem_address = 16'h0200;
    bus.pmem_wdata   = {4{64'hFEED_FACE_0000_0001}};
    bus.pmem_write   = 1'b1;
    w = 0;
    while (wbeat_log.size() < base + 2 && w < 50) begin @(posedge clk); #1; w++; end
    check_val("rst_beats", wbeat_log.size() - base, 2);
    reset_n = 1'b0;
    #1;
    check_val("rst_outs", outs_flat(), 0);
    check_val("rst_rdata", bus.pmem_rdata, 0);
    bus.pmem_write = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    do_req(1'b0, 1'b1, 16'h0200, '0);
    check_val("rst_rd_cmd", cmd_log[$], {1'b0, 16'h0200});

    // Random traffic with stalls against the scoreboard memory
    stall_en = 1'b1;
    rc = resp_cnt;
    exp_resps = 0;
    for (int i = 0; i < 100; i++) begin
      a = 16'h0400 + 16'($urandom_range(0, 7) * 32) + 16'($urandom_range(0, 31));
      op = int'($urandom_range(0, 2));
      for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
      do_req(op != 0, op != 1, a, l);
      exp_resps += (op == 2) ? 2 : 1;
    end
    check_val("rand_resp_cnt", resp_cnt - rc, exp_resps);
    check_val("rand_q_empty", exp_q.size(), 0);
    check_val("rand_err", bus.err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
